apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_master.sv | 172 +++++++++++++++++
 tb/tb_apb_arb_master.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration in IDLE, then a standard
// SETUP/ACCESS transfer with optional wait-state timeout and a DONE pulse.
module apb_arb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              REQ,
  input  logic [1:0]              REQ_WRITE,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [1:0]              DONE,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int                WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    last_q, last_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [1:0]              done_q, done_d;

  logic [1:0]              eligible;
  logic                    win;
  logic                    finish;
  logic [DATA_WIDTH-1:0]   fin_rdata;
  logic                    fin_err;

  // A requester being told DONE this cycle sits out this cycle's arbitration.
  always_comb begin
    eligible = REQ & ~done_q;
    win      = (eligible == 2'b11) ? ~last_q : eligible[1];
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    wait_d    = wait_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    done_d    = 2'b00;
    finish    = 1'b0;
    fin_rdata = '0;
    fin_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d  = SETUP;
          gnt_d    = win;
          last_d   = win;
          psel_d   = 1'b1;
          wait_d   = '0;
          pwrite_d = REQ_WRITE[win];
          paddr_d  = win ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]
                         : REQ_ADDR[ADDR_WIDTH-1:0];
          pwdata_d = win ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH]
                         : REQ_WDATA[DATA_WIDTH-1:0];
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          finish    = 1'b1;
          fin_rdata = pwrite_q ? '0 : PRDATA;
          fin_err   = PSLVERR;
        end else begin
          wait_d = wait_q + 1'b1;
          // Abort on the edge where the wait count reaches the limit.
          if (TIMEOUT > 0 && wait_d == TIMEOUT_C) begin
            finish    = 1'b1;
            fin_rdata = '0;
            fin_err   = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (finish) begin
      state_d       = IDLE;
      psel_d        = 1'b0;
      penable_d     = 1'b0;
      done_d[gnt_q] = 1'b1;
      rdata_d       = fin_rdata;
      err_d         = fin_err;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the reset branch is synchronous and clears all state.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      wait_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign DONE      = done_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: scripted requesters, a simple APB slave model and
// a scoreboard of expected completions checked whenever DONE pulses.
module tb_apb_arb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            PCLK = 1'b0;
  logic            PRESETn = 1'b0;
  logic [1:0]      REQ = 2'b00;
  logic [1:0]      REQ_WRITE = 2'b00;
  logic [2*AW-1:0] REQ_ADDR = '0;
  logic [2*DW-1:0] REQ_WDATA = '0;
  logic [1:0]      DONE;
  logic [DW-1:0]   RSP_RDATA;
  logic            RSP_ERR;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA = '0;
  logic            PREADY = 1'b0;
  logic            PSLVERR = 1'b0;

  apb_arb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial forever #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [1:0]    who;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          mon_en = 1'b0;
  logic          rst_at_edge = 1'b1;
  logic [DW-1:0] hold_rdata = '0;
  logic          hold_err = 1'b0;

  // Slave model: ready after slv_waits ACCESS cycles (-1 = never).
  int            slv_waits = 0;
  logic          slv_err_en = 1'b0;
  int            acc_cnt = 0;
  logic [DW-1:0] mem [0:255];

  initial forever begin
    @(negedge PCLK);
    if (PSEL && PENABLE) begin
      if (slv_waits >= 0 && acc_cnt >= slv_waits) begin
        PREADY  = 1'b1;
        PRDATA  = mem[PADDR];
        PSLVERR = slv_err_en;
      end else begin
        PREADY  = 1'b0;
        PRDATA  = 32'hDEAD_BEEF;
        PSLVERR = 1'b1;
      end
      acc_cnt++;
    end else begin
      PREADY  = 1'b0;
      PRDATA  = 32'hDEAD_BEEF;
      PSLVERR = 1'b0;
      acc_cnt = 0;
    end
  end

  initial forever begin
    @(posedge PCLK);
    rst_at_edge = !PRESETn;
  end

  // Scoreboard monitor: pops on each DONE, otherwise checks the response holds.
  initial forever begin
    @(negedge PCLK);
    if (mon_en) begin
      n_cmp++;
      if (rst_at_edge) begin
        hold_rdata = '0;
        hold_err   = 1'b0;
        if (DONE !== 2'b00) begin
          n_bad++;
          $display("FAIL done_in_reset: DONE=%b, required 00", DONE);
        end
      end else if (DONE !== 2'b00) begin
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL done_unexpected: DONE=%b with no transfer outstanding", DONE);
        end else begin
          mon_e = exp_q.pop_front();
          if ({DONE, RSP_RDATA, RSP_ERR} !== {mon_e.who, mon_e.rdata, mon_e.err}) begin
            n_bad++;
            $display("FAIL scoreboard: DONE=%b RSP_RDATA=%h RSP_ERR=%b, required DONE=%b RSP_RDATA=%h RSP_ERR=%b",
                     DONE, RSP_RDATA, RSP_ERR, mon_e.who, mon_e.rdata, mon_e.err);
          end
          hold_rdata = mon_e.rdata;
          hold_err   = mon_e.err;
        end
      end else if ({RSP_RDATA, RSP_ERR} !== {hold_rdata, hold_err}) begin
        n_bad++;
        $display("FAIL rsp_hold: RSP_RDATA=%h RSP_ERR=%b, required %h %b",
                 RSP_RDATA, RSP_ERR, hold_rdata, hold_err);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    REQ       = req;
    REQ_WRITE = wr;
    REQ_ADDR  = {a1, a0};
    REQ_WDATA = {d1, d0};
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    drive(2'b11, 2'b11, 8'h11, 8'h22, 32'h1111_1111, 32'h2222_2222);
    repeat (3) tick();
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctrl: PSEL/PENABLE/PWRITE=%b, required 000", {PSEL, PENABLE, PWRITE});
    end
    n_cmp++;
    if ({PADDR, PWDATA} !== '0) begin
      n_bad++;
      $display("FAIL reset_bus: PADDR=%h PWDATA=%h, required 0 0", PADDR, PWDATA);
    end
    n_cmp++;
    if ({DONE, RSP_RDATA, RSP_ERR} !== '0) begin
      n_bad++;
      $display("FAIL reset_rsp: DONE=%b RSP_RDATA=%h RSP_ERR=%b, required 0", DONE, RSP_RDATA, RSP_ERR);
    end
    drive(2'b00, 2'b00, 8'h00, 8'h00, '0, '0);
    PRESETn = 1'b1;
    mon_en  = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    slv_waits = 0;
    drive(2'b01, 2'b01, 8'h00, 8'h00, 32'hAAAA_5555, 32'h0);
    exp_q.push_back({2'b01, 32'h0, 1'b0});
    tick();  // SETUP
    drive(2'b00, 2'b00, 8'hEE, 8'hEE, 32'h1234_0000, 32'h0);
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b101, 8'h00, 32'hAAAA_5555}) begin
      n_bad++;
      $display("FAIL wr_setup: PSEL/PENABLE/PWRITE=%b PADDR=%h PWDATA=%h, required 101 00 aaaa5555",
               {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();  // ACCESS
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {3'b111, 8'h00, 32'hAAAA_5555}) begin
      n_bad++;
      $display("FAIL wr_access: PSEL/PENABLE/PWRITE=%b PADDR=%h PWDATA=%h, required 111 00 aaaa5555",
               {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick();  // DONE cycle
    n_cmp++;
    if ({DONE, PSEL, PENABLE} !== 4'b0100) begin
      n_bad++;
      $display("FAIL wr_done_timing: DONE=%b PSEL=%b PENABLE=%b, required 01 0 0", DONE, PSEL, PENABLE);
    end
    tick();
    n_cmp++;
    if ({PSEL, PWRITE, PADDR, PWDATA} !== {2'b01, 8'h00, 32'hAAAA_5555}) begin
      n_bad++;
      $display("FAIL idle_hold: PSEL=%b PWRITE=%b PADDR=%h PWDATA=%h, required 0 1 00 aaaa5555",
               PSEL, PWRITE, PADDR, PWDATA);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL wr_drain: %0d completions missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_contention();
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    slv_waits = 0;
    mem[8'h04] = 32'h1234_5678;
    mem[8'h08] = 32'hCAFE_F00D;
    drive(2'b11, 2'b00, 8'h04, 8'h08, 32'h0, 32'h0);
    exp_q.push_back({2'b01, 32'h1234_5678, 1'b0});
    exp_q.push_back({2'b10, 32'hCAFE_F00D, 1'b0});
    tick();  // SETUP for requester 0
    n_cmp++;
    if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 8'h04}) begin
      n_bad++;
      $display("FAIL cont_first: PSEL/PENABLE/PWRITE=%b PADDR=%h, required 100 04", {PSEL, PENABLE, PWRITE}, PADDR);
    end
    tick();
    tick();  // DONE[0]; requester 1 wins this edge
    REQ = 2'b10;
    tick();
    REQ = 2'b00;
    n_cmp++;
    if ({PSEL, PENABLE, PADDR} !== {2'b10, 8'h08}) begin
      n_bad++;
      $display("FAIL cont_second: PSEL/PENABLE=%b PADDR=%h, required 10 08", {PSEL, PENABLE}, PADDR);
    end
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL cont_drain: %0d completions missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    int dn;
    dn = 0;
    slv_waits = 0;
    drive(2'b11, 2'b00, 8'h04, 8'h08, 32'h0, 32'h0);
    exp_q.push_back({2'b01, 32'h1234_5678, 1'b0});
    exp_q.push_back({2'b10, 32'hCAFE_F00D, 1'b0});
    exp_q.push_back({2'b01, 32'h1234_5678, 1'b0});
    exp_q.push_back({2'b10, 32'hCAFE_F00D, 1'b0});
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      tick();
      if (DONE !== 2'b00) dn++;
      if (dn >= 3 && DONE === 2'b00) REQ = 2'b00;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rr_drain: %0d completions missing, required 0", exp_q.size());
    end
    REQ = 2'b00;
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    slv_waits = 0;
    drive(2'b01, 2'b00, 8'h04, 8'h00, 32'h0, 32'h0);
    exp_q.push_back({2'b01, 32'h1234_5678, 1'b0});
    exp_q.push_back({2'b01, 32'h1234_5678, 1'b0});
    tick();
    tick();
    tick();  // DONE: requester 0 ineligible at this edge
    tick();
    n_cmp++;
    if (PSEL !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_gap: PSEL=%b, required 0", PSEL);
    end
    tick();
    REQ = 2'b00;
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_regrant: PSEL/PENABLE=%b, required 10", {PSEL, PENABLE});
    end
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: %0d completions missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_wait_states();
    int pen;
    int stab_errs;
    pen = 0;
    stab_errs = 0;
    slv_waits = 3;
    mem[8'h10] = 32'h0BAD_F00D;
    drive(2'b10, 2'b00, 8'h00, 8'h10, 32'h0, 32'h77);
    exp_q.push_back({2'b10, 32'h0BAD_F00D, 1'b0});
    tick();
    drive(2'b00, 2'b11, 8'h55, 8'h66, 32'h99, 32'h88);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!PENABLE) break;
      pen++;
      if ({PSEL, PADDR, PWRITE, PWDATA} !== {1'b1, 8'h10, 1'b0, 32'h77}) stab_errs++;
    end
    n_cmp++;
    if (pen !== 4) begin
      n_bad++;
      $display("FAIL wait_penable: PENABLE high %0d cycles, required 4", pen);
    end
    n_cmp++;
    if (stab_errs !== 0) begin
      n_bad++;
      $display("FAIL wait_stable: %0d unstable ACCESS cycles, required 0", stab_errs);
    end
    n_cmp++;
    if (DONE !== 2'b10) begin
      n_bad++;
      $display("FAIL wait_done: DONE=%b, required 10", DONE);
    end
    tick();
    slv_waits = 0;
  endtask

  task automatic test_timeout();
    int pen;
    pen = 0;
    slv_waits = -1;
    drive(2'b01, 2'b00, 8'h20, 8'h00, 32'h0, 32'h0);
    exp_q.push_back({2'b01, 32'h0, 1'b1});
    tick();
    REQ = 2'b00;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!PENABLE) break;
      pen++;
    end
    n_cmp++;
    if (pen !== TO) begin
      n_bad++;
      $display("FAIL timeout_len: PENABLE high %0d cycles, required %0d", pen, TO);
    end
    n_cmp++;
    if ({PSEL, DONE} !== 3'b001) begin
      n_bad++;
      $display("FAIL timeout_exit: PSEL=%b DONE=%b, required 0 01", PSEL, DONE);
    end
    slv_waits = 0;
    tick();
  endtask

  task automatic test_slave_error();
    slv_waits  = 0;
    slv_err_en = 1'b1;
    drive(2'b01, 2'b01, 8'hFC, 8'h00, 32'h5A5A_5A5A, 32'h0);
    exp_q.push_back({2'b01, 32'h0, 1'b1});
    tick();
    REQ = 2'b00;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL slverr_drain: %0d completions missing, required 0", exp_q.size());
    end
    slv_err_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    slv_waits = -1;
    drive(2'b01, 2'b01, 8'h30, 8'h00, 32'h3333_3333, 32'h0);
    tick();
    REQ = 2'b00;
    tick();
    tick();
    n_cmp++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_in_access: PSEL/PENABLE=%b, required 11", {PSEL, PENABLE});
    end
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    n_cmp++;
    if ({PSEL, PENABLE, DONE} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_abandon: PSEL/PENABLE=%b DONE=%b, required 00 00", {PSEL, PENABLE}, DONE);
    end
    slv_waits = 0;
    repeat (3) tick();
    drive(2'b10, 2'b00, 8'h00, 8'h08, 32'h0, 32'h0);
    exp_q.push_back({2'b10, 32'hCAFE_F00D, 1'b0});
    tick();
    REQ = 2'b00;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL mid_recover: %0d completions missing, required 0", exp_q.size());
    end
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
    test_reset();
    test_single_write();
    test_contention();
    test_round_robin();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_slave_error();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
